// File: rtl/ppu_vga_scaler_if.sv
// PPU-side bus of the VGA scaler: pixel write strobe plus the line request handshake.
`timescale 1ns/1ps
interface ppu_vga_scaler_if;
  logic       ppu_valid;
  logic [7:0] ppu_x;
  logic [7:0] ppu_y;
  logic [5:0] ppu_index;
  logic       line_req;
  logic [7:0] line_req_num;

  modport master (
    output ppu_valid, ppu_x, ppu_y, ppu_index,
    input  line_req, line_req_num
  );

  modport slave (
    input  ppu_valid, ppu_x, ppu_y, ppu_index,
    output line_req, line_req_num
  );
endinterface

// File: rtl/ppu_vga_scaler.sv
// NES PPU 256x240 to 640x480@60 VGA line doubler with ping-pong line buffers and border fill.
// Optional PPU_VGA_SCANLINES_EN halves the colour of odd image rows.
`timescale 1ns/1ps
module ppu_vga_scaler #(
  parameter int unsigned H_VISIBLE    = 640,
  parameter int unsigned H_FRONT      = 16,
  parameter int unsigned H_SYNC       = 96,
  parameter int unsigned H_BACK       = 48,
  parameter int unsigned V_VISIBLE    = 480,
  parameter int unsigned V_FRONT      = 10,
  parameter int unsigned V_SYNC       = 2,
  parameter int unsigned V_BACK       = 33,
  parameter int unsigned H_OFFSET     = 64,
  parameter logic [11:0] BORDER_COLOR = 12'h000
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   pix_en,
  ppu_vga_scaler_if.slave        ppuBus,
  output logic                   underrun,
  output logic                   hSync_OUT,
  output logic                   vSync_OUT,
  output logic [11:0]            vgaColors_OUT
);

  localparam int unsigned H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int unsigned V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

  localparam logic [9:0] H_LAST    = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST    = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_VIS     = 10'(H_VISIBLE);
  localparam logic [9:0] V_VIS     = 10'(V_VISIBLE);
  localparam logic [9:0] HS_START  = 10'(H_VISIBLE + H_FRONT);
  localparam logic [9:0] HS_END    = 10'(H_VISIBLE + H_FRONT + H_SYNC);
  localparam logic [9:0] VS_START  = 10'(V_VISIBLE + V_FRONT);
  localparam logic [9:0] VS_END    = 10'(V_VISIBLE + V_FRONT + V_SYNC);
  localparam logic [9:0] IMG_START = 10'(H_OFFSET);
  localparam logic [9:0] IMG_END   = 10'(H_OFFSET + 512);
  localparam logic [9:0] REQ_LIMIT = 10'(V_VISIBLE - 1);

  typedef enum logic [1:0] {PixBlank, PixBorder, PixImage} pixKind_e;

  logic [9:0]  hCount, vCount;
  logic        hLast, vLast;
  logic        inVisible, inImage, lineStart, rowSel, lineBadNow;
  logic [7:0]  rdAddr;
  logic        wrEn;
  logic        reqFire;
  logic [7:0]  reqNum;
  logic [1:0]  fullQ, fullD;
  logic        lineBad;
  logic [5:0]  ram0 [256];
  logic [5:0]  ram1 [256];
  logic [5:0]  rdData;
  pixKind_e    s1Kind, s0Kind;
  logic        s1Hs, s1Vs;
  logic [11:0] palColor, imgColor, pixColor;

  // Raster counters
  assign hLast = (hCount == H_LAST);
  assign vLast = (vCount == V_LAST);

  always_ff @(posedge clock) begin
    if (reset) begin
      hCount <= '0;
      vCount <= '0;
    end else if (pix_en) begin
      if (hLast) begin
        hCount <= '0;
        vCount <= vLast ? 10'd0 : vCount + 10'd1;
      end else begin
        hCount <= hCount + 10'd1;
      end
    end
  end

  // Stage 0 decode
  assign inVisible  = (hCount < H_VIS) && (vCount < V_VIS);
  assign inImage    = (hCount >= IMG_START) && (hCount < IMG_END) && (vCount < V_VIS);
  assign lineStart  = (hCount == IMG_START) && (vCount < V_VIS);
  assign rowSel     = vCount[1];
  assign rdAddr     = inImage ? 8'((hCount - IMG_START) >> 1) : 8'd0;
  assign lineBadNow = lineStart ? !fullQ[rowSel] : lineBad;

  always_comb begin
    s0Kind = PixBlank;
    if (inVisible) s0Kind = (inImage && !lineBadNow) ? PixImage : PixBorder;
  end

  // Line buffers: writes ignore pix_en, reads advance with the pipeline
  assign wrEn = ppuBus.ppu_valid && (ppuBus.ppu_y < 8'd240);

  always_ff @(posedge clock) begin
    if (wrEn && !ppuBus.ppu_y[0]) ram0[ppuBus.ppu_x] <= ppuBus.ppu_index;
    if (wrEn && ppuBus.ppu_y[0])  ram1[ppuBus.ppu_x] <= ppuBus.ppu_index;
    if (pix_en) rdData <= rowSel ? ram1[rdAddr] : ram0[rdAddr];
  end

  // Request the next source row during the last VGA line of the current one
  assign reqFire = pix_en && (hCount == H_VIS) &&
                   ((vCount[0] && (vCount < REQ_LIMIT)) || vLast);
  assign reqNum  = vLast ? 8'd0 : vCount[8:1] + 8'd1;

  always_comb begin
    fullD = fullQ;
    if (reqFire) fullD[reqNum[0]] = 1'b0;
    // A completing write wins over a same-cycle clear
    if (wrEn && (ppuBus.ppu_x == 8'hFF)) fullD[ppuBus.ppu_y[0]] = 1'b1;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      fullQ               <= '0;
      ppuBus.line_req     <= 1'b0;
      ppuBus.line_req_num <= '0;
      underrun            <= 1'b0;
      lineBad             <= 1'b0;
    end else begin
      fullQ           <= fullD;
      ppuBus.line_req <= reqFire;
      if (reqFire) ppuBus.line_req_num <= reqNum;
      if (pix_en && lineStart) begin
        lineBad <= !fullQ[rowSel];
        if (!fullQ[rowSel]) underrun <= 1'b1;
      end
    end
  end

  // Stage 1
  always_ff @(posedge clock) begin
    if (reset) begin
      s1Kind <= PixBlank;
      s1Hs   <= 1'b1;
      s1Vs   <= 1'b1;
    end else if (pix_en) begin
      s1Kind <= s0Kind;
      s1Hs   <= !((hCount >= HS_START) && (hCount < HS_END));
      s1Vs   <= !((vCount >= VS_START) && (vCount < VS_END));
    end
  end

`ifdef PPU_VGA_SCANLINES_EN
  logic s1Odd;

  always_ff @(posedge clock) begin
    if (reset) s1Odd <= 1'b0;
    else if (pix_en) s1Odd <= vCount[0];
  end

  assign imgColor = s1Odd ? {1'b0, palColor[11:9], 1'b0, palColor[7:5], 1'b0, palColor[3:1]}
                          : palColor;
`else
  assign imgColor = palColor;
`endif

  // 2C02 palette quantised to RGB444, packed {B,G,R}
  always_comb begin
    palColor = 12'h000;
    case (rdData)
      6'h00: palColor = 12'h666; 6'h01: palColor = 12'h820; 6'h02: palColor = 12'hA11;
      6'h03: palColor = 12'hA03; 6'h04: palColor = 12'h705; 6'h05: palColor = 12'h406;
      6'h06: palColor = 12'h006; 6'h07: palColor = 12'h015; 6'h08: palColor = 12'h033;
      6'h09: palColor = 12'h040; 6'h0A: palColor = 12'h050; 6'h0B: palColor = 12'h040;
      6'h0C: palColor = 12'h440; 6'h10: palColor = 12'hAAA; 6'h11: palColor = 12'hD51;
      6'h12: palColor = 12'hF44; 6'h13: palColor = 12'hF27; 6'h14: palColor = 12'hC1A;
      6'h15: palColor = 12'h71B; 6'h16: palColor = 12'h23B; 6'h17: palColor = 12'h049;
      6'h18: palColor = 12'h066; 6'h19: palColor = 12'h083; 6'h1A: palColor = 12'h090;
      6'h1B: palColor = 12'h380; 6'h1C: palColor = 12'h870; 6'h20: palColor = 12'hFFF;
      6'h21: palColor = 12'hFB6; 6'h22: palColor = 12'hF99; 6'h23: palColor = 12'hF7C;
      6'h24: palColor = 12'hF6F; 6'h25: palColor = 12'hC6F; 6'h26: palColor = 12'h78F;
      6'h27: palColor = 12'h29E; 6'h28: palColor = 12'h0BB; 6'h29: palColor = 12'h0D8;
      6'h2A: palColor = 12'h3E5; 6'h2B: palColor = 12'h8E4; 6'h2C: palColor = 12'hDC4;
      6'h2D: palColor = 12'h444; 6'h30: palColor = 12'hFFF; 6'h31: palColor = 12'hFDC;
      6'h32: palColor = 12'hFDD; 6'h33: palColor = 12'hFCE; 6'h34: palColor = 12'hFCF;
      6'h35: palColor = 12'hECF; 6'h36: palColor = 12'hCCF; 6'h37: palColor = 12'hADF;
      6'h38: palColor = 12'h9EE; 6'h39: palColor = 12'h9EC; 6'h3A: palColor = 12'hAFB;
      6'h3B: palColor = 12'hCFB; 6'h3C: palColor = 12'hFEB; 6'h3D: palColor = 12'hBBB;
      default: palColor = 12'h000;
    endcase
  end

  always_comb begin
    pixColor = 12'h000;
    case (s1Kind)
      PixImage:  pixColor = imgColor;
      PixBorder: pixColor = BORDER_COLOR;
      default:   pixColor = 12'h000;
    endcase
  end

  // Stage 2: registered outputs
  always_ff @(posedge clock) begin
    if (reset) begin
      hSync_OUT     <= 1'b1;
      vSync_OUT     <= 1'b1;
      vgaColors_OUT <= 12'h000;
    end else if (pix_en) begin
      hSync_OUT     <= s1Hs;
      vSync_OUT     <= s1Vs;
      vgaColors_OUT <= pixColor;
    end
  end

endmodule

// File: tb/tb_ppu_vga_scaler.sv
// Randomised bench for ppu_vga_scaler against a raster-position reference model.
`timescale 1ns/1ps
module tb_ppu_vga_scaler;

  localparam int H_TOTAL = 800;
  localparam int RUN_PIX = 6 * H_TOTAL + 200;

  logic        clock = 1'b0;
  logic        reset;
  logic        pixEn;
  logic        underrun;
  logic        hSync;
  logic        vSync;
  logic [11:0] colors;

  ppu_vga_scaler_if ppuBus();

  ppu_vga_scaler dut (
    .clock         (clock),
    .reset         (reset),
    .pix_en        (pixEn),
    .ppuBus        (ppuBus),
    .underrun      (underrun),
    .hSync_OUT     (hSync),
    .vSync_OUT     (vSync),
    .vgaColors_OUT (colors)
  );

  always #5 clock = ~clock;

  int          checks = 0;
  int          failures = 0;
  int          pc = 0;
  logic [13:0] hist [4];
  bit          ready [240];
  logic [5:0]  rowData [240][256];
  bit          lineBadExp, underrunExp, lineReqExp;
  int          lineReqNumExp;
  int          pending = -1;

  task automatic checkValue(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (pix %0d)", tag, got, exp, pc);
    end
  endtask

  function automatic logic [11:0] palExp(input logic [5:0] idx);
    case (idx)
      6'h0F:   return 12'h000;
      6'h30:   return 12'hFFF;
      default: return 12'h666;
    endcase
  endfunction

  function automatic logic [5:0] randIdx();
    case ($urandom_range(0, 2))
      0:       return 6'h0F;
      1:       return 6'h30;
      default: return 6'h00;
    endcase
  endfunction

  // {hSync, vSync, colour} the display should show for pixel count c
  function automatic logic [13:0] pixelExp(input int c);
    int h, v;
    logic hs, vs;
    logic [11:0] col;
    h = c % H_TOTAL;
    v = c / H_TOTAL;
    hs = !(h >= 656 && h < 752);
    vs = !(v >= 490 && v < 492);
    col = 12'h000;
    if (h < 640 && v < 480) begin
      if (h >= 64 && h < 576 && !lineBadExp) begin
        col = palExp(rowData[v / 2][(h - 64) / 2]);
`ifdef PPU_VGA_SCANLINES_EN
        if (v % 2 == 1) col = {1'b0, col[11:9], 1'b0, col[7:5], 1'b0, col[3:1]};
`endif
      end else begin
        col = 12'h000;
      end
    end
    return {hs, vs, col};
  endfunction

  task automatic cycle(input bit rst, input bit pe, input bit wv, input int wx, input int wy,
                       input logic [5:0] wi);
    int h, v;
    logic [13:0] exp;
    @(negedge clock);
    reset            = rst;
    pixEn            = pe;
    ppuBus.ppu_valid = wv;
    ppuBus.ppu_x     = 8'(wx);
    ppuBus.ppu_y     = 8'(wy);
    ppuBus.ppu_index = wi;
    @(posedge clock);
    #1;
    lineReqExp = 1'b0;
    if (rst) begin
      pc = 0;
      underrunExp = 1'b0;
      lineBadExp = 1'b0;
      for (int r = 0; r < 240; r++) ready[r] = 1'b0;
    end else begin
      if (pe) begin
        h = pc % H_TOTAL;
        v = pc / H_TOTAL;
        if (h == 64 && v < 480) begin
          lineBadExp = !ready[v / 2];
          if (lineBadExp) underrunExp = 1'b1;
        end
        hist[pc % 4] = pixelExp(pc);
        if (h == 640 && ((v % 2 == 1 && v < 479) || v == 524)) begin
          lineReqExp = 1'b1;
          lineReqNumExp = (v == 524) ? 0 : v / 2 + 1;
          ready[lineReqNumExp] = 1'b0;
        end
        pc++;
      end
      if (wv && wy < 240) begin
        rowData[wy][wx] = wi;
        if (wx == 255) ready[wy] = 1'b1;
      end
    end
    exp = (pc >= 2) ? hist[(pc - 2) % 4] : {1'b1, 1'b1, 12'h000};
    checkValue("color", colors, exp[11:0]);
    checkValue("hSync", hSync, exp[13]);
    checkValue("vSync", vSync, exp[12]);
    checkValue("underrun", underrun, underrunExp);
    checkValue("lineReq", ppuBus.line_req, lineReqExp);
    if (lineReqExp) checkValue("lineReqNum", ppuBus.line_req_num, lineReqNumExp);
  endtask

  task automatic fillRow(input int row);
    for (int x = 0; x < 256; x++) cycle(1'b0, 1'b0, 1'b1, x, row, randIdx());
  endtask

  initial begin
    reset = 1'b1;
    pixEn = 1'b0;
    ppuBus.ppu_valid = 1'b0;
    ppuBus.ppu_x = '0;
    ppuBus.ppu_y = '0;
    ppuBus.ppu_index = '0;

    for (int i = 0; i < 3; i++) cycle(1'b1, 1'($urandom_range(0, 1)), 1'b0, 0, 0, 6'h0);

    // Row 0 pre-filled with timing frozen; columns 0/1 give a known dark/white edge
    for (int x = 0; x < 256; x++) begin
      logic [5:0] idx;
      idx = (x == 0) ? 6'h0F : ((x == 1 || x == 5) ? 6'h30 : randIdx());
      cycle(1'b0, 1'b0, 1'b1, x, 0, idx);
    end
    // Out-of-range rows must neither write nor mark a buffer full
    cycle(1'b0, 1'b0, 1'b1, 5, 240, 6'h0F);
    cycle(1'b0, 1'b0, 1'b1, 255, 241, 6'h30);

    // Row 1 is never supplied, every other requested row is filled while timing is held
    for (int g = 0; g < 20000 && pc < RUN_PIX; g++) begin
      if (pending >= 0) begin
        if (pending != 1 && pending < 240) fillRow(pending);
        pending = -1;
      end
      cycle(1'b0, 1'($urandom_range(0, 3) != 0), 1'b0, 0, 0, 6'h0);
      if (ppuBus.line_req) pending = int'(ppuBus.line_req_num);
    end
    checkValue("runLength", pc >= RUN_PIX, 1'b1);

    // Mid-frame reset, then restart with empty buffers
    cycle(1'b1, 1'b1, 1'b0, 0, 0, 6'h0);
    for (int i = 0; i < 300; i++) cycle(1'b0, 1'b1, 1'b0, 0, 0, 6'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
